vscale_hasti_sram_slave: RTL and testbench

VSCALE_HASTI_SRAM_SLAVE -- requirements
Module: vscale_hasti_sram_slave

---
 rtl/vscale_hasti_sram_slave.sv | 141 ++++++++++++++
 tb/tb_vscale_hasti_sram_slave.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_hasti_sram_slave.sv
// AHB-Lite (HASTI) SRAM slave: single-port word memory with byte-lane writes,
// optional data-phase wait states and a two-cycle ERROR response.
module vscale_hasti_sram_slave #(
    parameter int unsigned NWORDS      = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hmastlock,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp
);

    localparam int unsigned AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [2:0]  size_q, size_d;

    logic [31:0] mem [NWORDS];

    logic          accept;
    logic          req_err;
    logic [3:0]    be;
    logic [AW-1:0] widx;
    logic          unused;

    assign unused = ^{hburst, hmastlock, hprot, htrans[0], addr_q, size_q[2]};

    assign accept = hready && hsel && htrans[1];
    assign widx   = addr_q[AW+1:2];

    always_comb begin
        req_err = 1'b0;
        if ({2'b00, haddr[31:2]} >= NWORDS)           req_err = 1'b1;
        if (hsize > 3'd2)                              req_err = 1'b1;
        if (hsize == 3'd1 && haddr[0])                 req_err = 1'b1;
        if (hsize == 3'd2 && haddr[1:0] != 2'b00)      req_err = 1'b1;
    end

    // Handshake outputs decode from state alone so acceptance never loops back into them.
    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        case (state_q)
            S_WAIT: hready = 1'b0;
            S_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            S_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_DATA;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    addr_d  = haddr;
                    write_d = hwrite;
                    size_d  = hsize;
                    if (req_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        case (size_q[1:0])
            2'd0:    be = 4'b0001 << addr_q[1:0];
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Memory has no reset; reset forces state to IDLE, which blocks any pending write.
    always_ff @(posedge clk) begin
        if (state_q == S_DATA && write_q) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    assign hrdata = (state_q == S_DATA && !write_q) ? mem[widx] : '0;

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Bench for vscale_hasti_sram_slave: three instances (0, 2 and 3 wait states)
// driven from a transaction queue and checked against a word-array model.
module tb_vscale_hasti_sram_slave;

    localparam int unsigned NW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [3];
    logic        hsel      [3];
    logic [31:0] haddr     [3];
    logic        hwrite    [3];
    logic [2:0]  hsize     [3];
    logic [2:0]  hburst    [3];
    logic        hmastlock [3];
    logic [3:0]  hprot     [3];
    logic [1:0]  htrans    [3];
    logic [31:0] hwdata    [3];
    logic [31:0] hrdata    [3];
    logic        hready    [3];
    logic        hresp     [3];

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            vscale_hasti_sram_slave #(
                .NWORDS     (NW),
                .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
            ) u_dut (
                .clk      (clk),
                .reset    (rst[g]),
                .hsel     (hsel[g]),
                .haddr    (haddr[g]),
                .hwrite   (hwrite[g]),
                .hsize    (hsize[g]),
                .hburst   (hburst[g]),
                .hmastlock(hmastlock[g]),
                .hprot    (hprot[g]),
                .htrans   (htrans[g]),
                .hwdata   (hwdata[g]),
                .hrdata   (hrdata[g]),
                .hready   (hready[g]),
                .hresp    (hresp[g])
            );
        end
    endgenerate

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xact_t;

    xact_t       q[$];
    logic [31:0] mdl [3][NW];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_rd;
    logic [31:0] saved;

    function automatic int ws_of(int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    function automatic bit is_err(xact_t t);
        if ((t.addr >> 2) >= NW)                 return 1'b1;
        if (t.size > 3'd2)                       return 1'b1;
        if (t.size == 3'd1 && t.addr[0])         return 1'b1;
        if (t.size == 3'd2 && t.addr[1:0] != 0)  return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic add(bit sel, logic [1:0] tr, bit wr, logic [2:0] sz,
                       logic [31:0] a, logic [31:0] wd);
        xact_t t;
        t.sel = sel; t.trans = tr; t.wr = wr; t.size = sz; t.addr = a; t.wdata = wd;
        q.push_back(t);
    endtask

    task automatic drive_idle(int d);
        hsel[d]      = 1'b0;
        htrans[d]    = 2'd0;
        haddr[d]     = $urandom;
        hwrite[d]    = 1'($urandom);
        hsize[d]     = 3'($urandom);
        hburst[d]    = 3'($urandom);
        hmastlock[d] = 1'($urandom);
        hprot[d]     = 4'($urandom);
        hwdata[d]    = $urandom;
    endtask

    task automatic mdl_write(int d, xact_t t);
        int unsigned w  = t.addr >> 2;
        int unsigned l0 = t.addr % 4;
        int unsigned nb = 1 << t.size;
        for (int unsigned b = l0; b < l0 + nb; b++)
            mdl[d][w][8*b +: 8] = t.wdata[8*b +: 8];
    endtask

    // Plays the queue against instance d, back-to-back, holding address phases while stalled.
    task automatic run(int d);
        int          i    = 0;
        bit          pend = 0;
        bit          perr = 0;
        int          k    = 0;
        int          cyc  = 0;
        xact_t       p;
        bit          er, ep, comp, acc;
        logic [31:0] ed;
        while ((i < q.size() || pend) && cyc < 2000) begin
            if (!pend) begin
                er = 1'b1; ep = 1'b0; ed = '0;
            end else if (perr) begin
                er = (k == 1); ep = 1'b1; ed = '0;
            end else begin
                er = (k == ws_of(d)); ep = 1'b0;
                ed = (er && !p.wr) ? mdl[d][int'(p.addr >> 2)] : 32'h0;
            end
            chk("hready", 32'(hready[d]), 32'(er));
            chk("hresp",  32'(hresp[d]),  32'(ep));
            chk("hrdata", hrdata[d], ed);
            if (pend && er && !p.wr && !perr) last_rd = hrdata[d];
            comp = pend && er;
            drive_idle(d);
            if (i < q.size()) begin
                hsel[d]   = q[i].sel;
                htrans[d] = q[i].trans;
                hwrite[d] = q[i].wr;
                hsize[d]  = q[i].size;
                haddr[d]  = q[i].addr;
            end
            hwdata[d] = (comp && p.wr && !perr) ? p.wdata : $urandom;
            acc = er && (i < q.size()) && q[i].sel && q[i].trans[1];
            @(posedge clk); #1;
            cyc++;
            if (comp && p.wr && !perr) mdl_write(d, p);
            if (comp) pend = 0;
            else if (pend) k++;
            if (er && i < q.size()) begin
                if (acc) begin
                    p = q[i]; pend = 1; k = 0; perr = is_err(p);
                end
                i++;
            end
        end
        chk("cycle_budget", 32'(i < q.size() || pend), 32'h0);
        q.delete();
        drive_idle(d);
    endtask

    initial begin
        bit          r_sel, r_wr;
        logic [1:0]  r_tr;
        logic [2:0]  r_sz;
        int unsigned r;

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            drive_idle(d);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_hready", 32'(hready[d]), 32'h1);
            chk("rst_hresp",  32'(hresp[d]),  32'h0);
            chk("rst_hrdata", hrdata[d], 32'h0);
            rst[d] = 1'b0;
        end

        for (int d = 0; d < 3; d++) begin
            for (int unsigned w = 0; w < NW; w++) add(1, 2'd2, 1, 3'd2, w * 4, $urandom);
            run(d);
        end

        // Word write then read, no wait states
        add(1, 2'd2, 1, 3'd2, 32'h10, 32'hDEADBEEF);
        add(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
        run(0);
        chk("wr_rd_word", last_rd, 32'hDEADBEEF);

        // Byte and half-word lanes
        add(1, 2'd2, 1, 3'd2, 32'h20, 32'h11223344);
        add(1, 2'd3, 1, 3'd0, 32'h22, 32'h00AA0000);
        add(1, 2'd2, 0, 3'd2, 32'h20, 32'h0);
        run(0);
        chk("byte_lane", last_rd, 32'h11AA3344);
        add(1, 2'd2, 1, 3'd1, 32'h20, 32'h00005566);
        add(1, 2'd2, 0, 3'd2, 32'h20, 32'h0);
        run(0);
        chk("half_lane", last_rd, 32'h11AA5566);

        // Out of range and misaligned transfers
        saved = mdl[0][1];
        add(1, 2'd2, 0, 3'd2, NW * 4, 32'h0);
        add(1, 2'd2, 1, 3'd2, 32'h6, 32'hCAFEF00D);
        add(1, 2'd2, 0, 3'd2, 32'h4, 32'h0);
        run(0);
        chk("err_no_write", last_rd, saved);

        // BUSY and deselected transfers do nothing
        saved = mdl[0][2];
        add(1, 2'd1, 1, 3'd2, 32'h8, 32'h12345678);
        add(0, 2'd2, 1, 3'd2, 32'h8, 32'h87654321);
        add(1, 2'd0, 1, 3'd2, 32'h8, 32'h0BADF00D);
        add(1, 2'd2, 0, 3'd2, 32'h8, 32'h0);
        run(0);
        chk("idle_no_write", last_rd, saved);

        // Wait states with a held follow-on address phase
        add(1, 2'd2, 0, 3'd2, 32'h0, 32'h0);
        add(1, 2'd2, 0, 3'd2, 32'h4, 32'h0);
        add(1, 2'd2, 1, 3'd2, 32'h4, 32'hA5A5A5A5);
        add(1, 2'd2, 0, 3'd2, 32'h4, 32'h0);
        run(1);
        chk("ws_rd_after_wr", last_rd, 32'hA5A5A5A5);

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                r     = $urandom_range(0, 9);
                r_sel = (r != 0);
                r_tr  = (r == 1) ? 2'd0 : ((r == 2) ? 2'd1 : 2'($urandom_range(2, 3)));
                r_sz  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                r_wr  = 1'($urandom);
                add(r_sel, r_tr, r_wr, r_sz, $urandom_range(0, NW * 4 + 7), $urandom);
            end
            run(d);
        end

        // Reset during the wait phase of a write aborts it
        saved     = mdl[2][16];
        hsel[2]   = 1'b1;
        htrans[2] = 2'd2;
        hwrite[2] = 1'b1;
        hsize[2]  = 3'd2;
        haddr[2]  = 32'h40;
        @(posedge clk); #1;
        drive_idle(2);
        chk("rst_pre_wait", 32'(hready[2]), 32'h0);
        @(posedge clk); #3;
        rst[2] = 1'b1;
        #1;
        chk("rst_mid_hready", 32'(hready[2]), 32'h1);
        chk("rst_mid_hresp",  32'(hresp[2]),  32'h0);
        chk("rst_mid_hrdata", hrdata[2], 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst[2] = 1'b0;
        add(1, 2'd2, 0, 3'd2, 32'h40, 32'h0);
        run(2);
        chk("rst_no_write", last_rd, saved);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
